// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colour type and range helper for the scan driver slice.
package vga_pkg;

  // 640x480@60 timing with a 50 MHz system clock
  localparam int unsigned DEF_CLK_DIV  = 2;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam logic [23:0] DEF_BG_RGB   = 24'h000000;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Inclusive range test used by the sync decoders
  function automatic logic in_range(input int unsigned v, input int unsigned lo,
                                    input int unsigned hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: counts 0..TOTAL-1 on each enable and flags the wrapping enable.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [9:0] cnt,
  output logic       wrap
);

  localparam logic [9:0] LAST = 10'(TOTAL - 1);

  assign wrap = en && (cnt == LAST);

  // Axis position register, wraps back to zero after the last position
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 10'd1;
    end
  end

endmodule

// File: rtl/vga_scan_driver.sv
// VGA scan driver: pixel divider, H/V scan counters, sync decode and registered DAC outputs.
module vga_scan_driver
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic [23:0] BG_RGB   = DEF_BG_RGB
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] Q_X,
  output logic [9:0] Q_Y,
  input  logic       visible_in,
  input  logic [7:0] R_in,
  input  logic [7:0] G_in,
  input  logic [7:0] B_in,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk,
  output logic       pix_tick,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_LO   = H_ACTIVE + H_FP;
  localparam int unsigned HS_HI   = HS_LO + H_SYNC - 1;
  localparam int unsigned VS_LO   = V_ACTIVE + V_FP;
  localparam int unsigned VS_HI   = VS_LO + V_SYNC - 1;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (H_TOTAL > 1024) begin : g_bad_h_total
    $error("vga_scan_driver: H_TOTAL does not fit the 10-bit counter");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $error("vga_scan_driver: V_TOTAL does not fit the 10-bit counter");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_scan_driver: CLK_DIV must be at least 1");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic             run_q;
  logic             origin_q;
  logic             h_wrap;
  logic             v_wrap;
  logic             hs_d;
  logic             vs_d;
  logic             blank_n_d;
  rgb_t             rgb_d;
  rgb_t             rgb_q;

  // Next divider phase
  always_comb begin
    div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  end

  // Pixel divider and DAC clock; run_q keeps the tick low on the cycle right after reset
  // so that CLK_DIV=1 also honours the zero reset value of pix_tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      run_q   <= 1'b0;
      vga_clk <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      run_q   <= 1'b1;
      vga_clk <= (CLK_DIV == 1) ? 1'b1 : (32'(div_nxt) >= (CLK_DIV / 2));
    end
  end

  assign pix_tick = run_q && (div_cnt == DIV_LAST);

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_tick),
    .cnt  (Q_X),
    .wrap (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_tick & h_wrap),
    .cnt  (Q_Y),
    .wrap (v_wrap)
  );

  // Origin flag: set by reset or by the frame wrap, cleared by the tick that leaves (0,0);
  // equivalent to decoding Q_X==0 && Q_Y==0 without a 20-bit compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      origin_q <= 1'b1;
    end else if (v_wrap) begin
      origin_q <= 1'b1;
    end else if (pix_tick) begin
      origin_q <= 1'b0;
    end
  end

  assign frame_start = pix_tick && origin_q;

  // Sync/blank decode and colour select for the current scan position
  always_comb begin
    blank_n_d = (32'(Q_X) < H_ACTIVE) && (32'(Q_Y) < V_ACTIVE);
    hs_d      = ~in_range(32'(Q_X), HS_LO, HS_HI);
    vs_d      = ~in_range(32'(Q_Y), VS_LO, VS_HI);
    rgb_d     = '0;
    if (blank_n_d) begin
      rgb_d = visible_in ? {R_in, G_in, B_in} : BG_RGB;
    end
  end

  // Output stage: one pixel of latency, holds between ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else if (pix_tick) begin
      rgb_q       <= rgb_d;
      vga_hs      <= hs_d;
      vga_vs      <= vs_d;
      vga_blank_n <= blank_n_d;
    end
  end

  assign vga_r      = rgb_q.r;
  assign vga_g      = rgb_q.g;
  assign vga_b      = rgb_q.b;
  assign vga_sync_n = 1'b0;

endmodule
